// File: rtl/ifetcher_isplit.sv
// Splits 4-instruction lines from the fetch buffer into single instructions for decode.
// Define IFETCHER_ISPLIT_PREFETCH_EN to add a shadow line that removes the per-line bubble.
module ifetcher_isplit #(
    parameter int unsigned   IW       = 32,
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            iClk,
    input  logic            resetN,
    input  logic            iClear,
    input  logic [AW-1:0]   iRedirectPC,
    input  logic            iEmpty,
    output logic            oRE,
    input  logic [IW*4-1:0] iRD,
    output logic            oValid,
    input  logic            iReady,
    output logic [IW-1:0]   oInstr,
    output logic [AW-1:0]   oPC
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW*4-1:0] line_q, line_d;
    logic [1:0]      slot;
    logic            xfer;

    assign slot   = pc_q[3:2];
    assign oValid = (state_q == StHold);
    assign oInstr = line_q[IW*32'(slot) +: IW];
    assign oPC    = pc_q;
    assign xfer   = oValid & iReady;

`ifdef IFETCHER_ISPLIT_PREFETCH_EN
    logic [IW*4-1:0] shadow_q, shadow_d;
    logic            shadow_vld_q, shadow_vld_d;
    logic            pend_q, pend_d;

    assign oRE = ~iEmpty & ~iClear &
                 ((state_q == StIdle) | ((state_q == StHold) & ~shadow_vld_q & ~pend_q));
`else
    assign oRE = (state_q == StIdle) & ~iEmpty & ~iClear;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        line_d  = line_q;
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        pend_d       = pend_q;
`endif
        if (iClear) begin
            state_d = StIdle;
            pc_d    = {iRedirectPC[AW-1:2], 2'b00};
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
            shadow_vld_d = 1'b0;
            pend_d       = 1'b0;
`endif
        end else begin
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
            pend_d = (state_q == StHold) & oRE;
            if (pend_q) begin
                shadow_d     = iRD;
                shadow_vld_d = 1'b1;
            end
`endif
            case (state_q)
                StIdle: if (oRE) state_d = StWait;
                StWait: begin
                    line_d  = iRD;
                    state_d = StHold;
                end
                StHold: begin
                    if (xfer) begin
                        pc_d = pc_q + AW'(4);
                        if (slot == 2'd3) begin
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
                            // Shadow being filled this cycle is forwarded straight from iRD.
                            if (shadow_vld_q) begin
                                line_d       = shadow_q;
                                shadow_vld_d = 1'b0;
                            end else if (pend_q) begin
                                line_d       = iRD;
                                shadow_vld_d = 1'b0;
                            end else begin
                                state_d = StIdle;
                            end
`else
                            state_d = StIdle;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            line_q  <= '0;
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            line_q  <= line_d;
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            pend_q       <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetcher_isplit.sv
// Self-checking bench for ifetcher_isplit: directed scenarios plus a randomized run
// against a line-level expected-instruction model.
module tb_ifetcher_isplit;

    localparam int unsigned   IW       = 32;
    localparam int unsigned   AW       = 32;
    localparam logic [AW-1:0] RESET_PC = 32'h0;

    logic            iClk = 1'b0;
    logic            resetN;
    logic            iClear;
    logic [AW-1:0]   iRedirectPC;
    logic            iEmpty;
    logic            oRE;
    logic [IW*4-1:0] iRD;
    logic            oValid;
    logic            iReady;
    logic [IW-1:0]   oInstr;
    logic [AW-1:0]   oPC;

    int tests = 0;
    int fails = 0;

    logic [IW*4-1:0] buf_q[$];

    logic            s_re, s_valid, s_xfer, s_clear;
    logic [IW-1:0]   s_instr;
    logic [AW-1:0]   s_pc, s_redir;
    logic            popped;
    logic [IW*4-1:0] popped_line;

    ifetcher_isplit #(
        .IW(IW),
        .AW(AW),
        .RESET_PC(RESET_PC)
    ) dut (
        .iClk(iClk),
        .resetN(resetN),
        .iClear(iClear),
        .iRedirectPC(iRedirectPC),
        .iEmpty(iEmpty),
        .oRE(oRE),
        .iRD(iRD),
        .oValid(oValid),
        .iReady(iReady),
        .oInstr(oInstr),
        .oPC(oPC)
    );

    always #5 iClk = ~iClk;

    task automatic push(input logic [IW*4-1:0] ln);
        buf_q.push_back(ln);
        iEmpty = 1'b0;
    endtask

    // One clock: sample outputs at negedge, then model the registered buffer read port.
    task automatic cycle();
        @(negedge iClk);
        s_re    = oRE;
        s_valid = oValid;
        s_xfer  = oValid & iReady;
        s_instr = oInstr;
        s_pc    = oPC;
        s_clear = iClear;
        s_redir = iRedirectPC;
        if (iClear) buf_q.delete();
        @(posedge iClk);
        #1;
        popped = 1'b0;
        iRD    = {$urandom, $urandom, $urandom, $urandom};
        if (s_re) begin
            tests++;
            if (buf_q.size() == 0) begin
                fails++;
                $display("FAIL underflow: oRE=1 with empty buffer, want oRE=0");
            end else begin
                popped_line = buf_q.pop_front();
                iRD         = popped_line;
                popped      = 1'b1;
            end
        end
        iEmpty = (buf_q.size() == 0);
    endtask

    task automatic do_reset();
        resetN      = 1'b0;
        iClear      = 1'b0;
        iReady      = 1'b0;
        iRedirectPC = '0;
        iRD         = '0;
        buf_q.delete();
        iEmpty = 1'b1;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        resetN = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (oValid !== 1'b0 || oRE !== 1'b0 || oPC !== RESET_PC) begin
            fails++;
            $display("FAIL reset_state: valid=%b re=%b pc=%h want 0 0 %h", oValid, oRE, oPC,
                     RESET_PC);
        end
        push(128'h1);
        #1;
        tests++;
        if (oRE !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_re: got %b want 1", oRE);
        end
        buf_q.delete();
        iEmpty = 1'b1;
        #1;
    endtask

    task automatic test_single_line();
        logic [IW*4-1:0] ln = 128'h44444444_33333333_22222222_11111111;
        iReady = 1'b1;
        push(ln);
        for (int i = 0; i < 8; i++) begin
            cycle();
            tests++;
            if (s_re !== (i == 0)) begin
                fails++;
                $display("FAIL single_re idx%0d: got %b want %b", i, s_re, (i == 0));
            end
            tests++;
            if (s_valid !== (i >= 2 && i <= 5)) begin
                fails++;
                $display("FAIL single_valid idx%0d: got %b want %b", i, s_valid,
                         (i >= 2 && i <= 5));
            end
            if (i >= 2 && i <= 5) begin
                tests++;
                if (s_instr !== ln[IW*(i-2) +: IW] || s_pc !== AW'(4 * (i - 2))) begin
                    fails++;
                    $display("FAIL single_data idx%0d: got %h@%h want %h@%h", i, s_instr, s_pc,
                             ln[IW*(i-2) +: IW], AW'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [IW*4-1:0] ln = 128'h44444444_33333333_22222222_11111111;
        do_reset();
        iReady = 1'b1;
        push(ln);
        repeat (3) cycle();
        tests++;
        if (s_xfer !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'h11111111) begin
            fails++;
            $display("FAIL bp_slot0: got x=%b %h@%h want 1 11111111@0", s_xfer, s_instr, s_pc);
        end
        iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (s_valid !== 1'b1 || s_instr !== 32'h22222222 || s_pc !== 32'h4 || s_re !== 1'b0)
            begin
                fails++;
                $display("FAIL bp_hold %0d: got v=%b re=%b %h@%h want 1 0 22222222@4", i,
                         s_valid, s_re, s_instr, s_pc);
            end
        end
        iReady = 1'b1;
        cycle();
        tests++;
        if (s_xfer !== 1'b1 || s_instr !== 32'h22222222 || s_pc !== 32'h4) begin
            fails++;
            $display("FAIL bp_release: got x=%b %h@%h want 1 22222222@4", s_xfer, s_instr, s_pc);
        end
        cycle();
        cycle();
        tests++;
        if (s_xfer !== 1'b1 || s_instr !== 32'h44444444 || s_pc !== 32'hC) begin
            fails++;
            $display("FAIL bp_slot3: got x=%b %h@%h want 1 44444444@c", s_xfer, s_instr, s_pc);
        end
        cycle();
        tests++;
        if (s_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_idle: got valid=%b want 0", s_valid);
        end
    endtask

    task automatic test_redirect();
        iReady      = 1'b1;
        iClear      = 1'b1;
        iRedirectPC = 32'h10B;
        cycle();
        iClear = 1'b0;
        push(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        cycle();
        tests++;
        if (s_re !== 1'b1 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_re: got re=%b v=%b want 1 0", s_re, s_valid);
        end
        cycle();
        cycle();
        tests++;
        if (s_xfer !== 1'b1 || s_pc !== 32'h108 || s_instr !== 32'hCCCCCCCC) begin
            fails++;
            $display("FAIL redir_first: got x=%b %h@%h want 1 cccccccc@108", s_xfer, s_instr,
                     s_pc);
        end
        cycle();
        tests++;
        if (s_xfer !== 1'b1 || s_pc !== 32'h10C || s_instr !== 32'hDDDDDDDD) begin
            fails++;
            $display("FAIL redir_second: got x=%b %h@%h want 1 dddddddd@10c", s_xfer, s_instr,
                     s_pc);
        end
        cycle();
        tests++;
        if (s_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_idle: got valid=%b want 0", s_valid);
        end
    endtask

    task automatic test_clear_in_wait();
        logic [IW*4-1:0] ly = 128'h0000D004_0000C003_0000B002_0000A001;
        iReady = 1'b1;
        push(128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE);
        cycle();
        tests++;
        if (s_re !== 1'b1) begin
            fails++;
            $display("FAIL cw_re: got %b want 1", s_re);
        end
        iClear      = 1'b1;
        iRedirectPC = 32'h204;
        cycle();
        iClear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            tests++;
            if (s_valid !== 1'b0 || s_re !== 1'b0) begin
                fails++;
                $display("FAIL cw_discard %0d: got v=%b re=%b want 0 0", i, s_valid, s_re);
            end
        end
        push(ly);
        cycle();
        cycle();
        for (int j = 1; j < 4; j++) begin
            cycle();
            tests++;
            if (s_xfer !== 1'b1 || s_pc !== (32'h200 + AW'(4 * j)) || s_instr !== ly[IW*j +: IW])
            begin
                fails++;
                $display("FAIL cw_issue slot%0d: got x=%b %h@%h want 1 %h@%h", j, s_xfer,
                         s_instr, s_pc, ly[IW*j +: IW], 32'h200 + AW'(4 * j));
            end
        end
        cycle();
    endtask

    task automatic test_empty();
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if (s_re !== 1'b0 || s_valid !== 1'b0) begin
                fails++;
                $display("FAIL empty %0d: got re=%b v=%b want 0 0", i, s_re, s_valid);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        iReady = 1'b0;
        push(128'h12345678_12345678_12345678_12345678);
        repeat (3) cycle();
        tests++;
        if (s_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_hold_pre: got valid=%b want 1", s_valid);
        end
        resetN = 1'b0;
        #1;
        tests++;
        if (oValid !== 1'b0 || oPC !== RESET_PC) begin
            fails++;
            $display("FAIL rst_mid_hold: got v=%b pc=%h want 0 %h", oValid, oPC, RESET_PC);
        end
        do_reset();
    endtask

    task automatic test_throughput();
        logic [IW*4-1:0] ln;
        int first = -1;
        int last  = -1;
        int n     = 0;
        int want_span;
`ifdef IFETCHER_ISPLIT_PREFETCH_EN
        want_span = 12;
`else
        want_span = 16;
`endif
        do_reset();
        iReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) ln[IW*j +: IW] = 32'hA0000000 + 32'(4 * k + j);
            push(ln);
        end
        for (int c = 0; c < 40 && n < 12; c++) begin
            cycle();
            if (s_xfer) begin
                if (first < 0) first = c;
                tests++;
                if (s_pc !== AW'(4 * n) || s_instr !== 32'hA0000000 + 32'(n)) begin
                    fails++;
                    $display("FAIL thru_data %0d: got %h@%h want %h@%h", n, s_instr, s_pc,
                             32'hA0000000 + 32'(n), AW'(4 * n));
                end
                n++;
                last = c;
            end
        end
        tests++;
        if (n != 12 || (last - first + 1) != want_span) begin
            fails++;
            $display("FAIL thru_span: got %0d xfers in %0d cycles want 12 in %0d", n,
                     last - first + 1, want_span);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] m_pc;
        logic [AW-1:0] e_pc[$];
        logic [IW-1:0] e_instr[$];
        logic [AW-1:0] ep;
        logic [IW-1:0] ei;
        logic          pv = 1'b0;
        logic [IW-1:0] pi = '0;
        logic [AW-1:0] pp = '0;
        do_reset();
        m_pc = RESET_PC;
        for (int c = 0; c < 700; c++) begin
            if (c < 600) begin
                iReady      = ($urandom_range(3) != 0);
                iClear      = ($urandom_range(47) == 0);
                iRedirectPC = ($urandom_range(1) != 0) ? $urandom
                                                       : (32'hFFFFFFF0 | 32'($urandom_range(15)));
                if (buf_q.size() < 3 && $urandom_range(2) == 0)
                    push({$urandom, $urandom, $urandom, $urandom});
            end else begin
                iReady = 1'b1;
                iClear = 1'b0;
            end
            cycle();
            if (pv) begin
                tests++;
                if (s_valid !== 1'b1 || s_instr !== pi || s_pc !== pp) begin
                    fails++;
                    $display("FAIL rand_stable c%0d: got v=%b %h@%h want 1 %h@%h", c, s_valid,
                             s_instr, s_pc, pi, pp);
                end
            end
            pv = s_valid && !s_xfer && !s_clear;
            pi = s_instr;
            pp = s_pc;
            if (s_xfer && !s_clear) begin
                tests++;
                if (e_pc.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra c%0d: got %h@%h want no transfer", c, s_instr, s_pc);
                end else begin
                    ep = e_pc.pop_front();
                    ei = e_instr.pop_front();
                    if (s_pc !== ep || s_instr !== ei) begin
                        fails++;
                        $display("FAIL rand_data c%0d: got %h@%h want %h@%h", c, s_instr, s_pc,
                                 ei, ep);
                    end
                end
            end
            if (s_clear) begin
                e_pc.delete();
                e_instr.delete();
                m_pc = {s_redir[AW-1:2], 2'b00};
            end
            if (popped) begin
                for (int j = int'(m_pc[3:2]); j < 4; j++) begin
                    e_pc.push_back(m_pc);
                    e_instr.push_back(popped_line[IW*j +: IW]);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        tests++;
        if (e_pc.size() != 0 || buf_q.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: got %0d pending, %0d buffered want 0 0", e_pc.size(),
                     buf_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_backpressure();
        test_redirect();
        test_clear_in_wait();
        test_empty();
        test_reset_mid_hold();
        test_throughput();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetcher_isplit.md
Name: ifetcher_isplit

Overview:
- Downstream consumer of the ifetcher receive-data buffer. Pops 4-instruction lines (IW*4 bits) from the buffer and issues one IW-bit instruction per handshake to decode, together with its PC.
- Handles redirect/clear: discards held and in-flight data, then restarts at the slot selected by the redirect PC.
- The buffer read port is registered: data appears on iRD the cycle after oRE.

Parameters:
- IW, 32, instruction width in bits
- AW, 32, PC width in bits
- RESET_PC, 0, PC loaded at reset; must be IW/8-byte aligned

Ports:
- iClk  input  1  clock
- resetN  input  1  reset, asynchronous, active-low
- iClear  input  1  synchronous flush/redirect, same cycle as the buffer clear
- iRedirectPC  input  AW  new PC, sampled when iClear=1
- iEmpty  input  1  buffer empty flag
- oRE  output  1  buffer read enable
- iRD  input  IW*4  buffer read data, valid the cycle after oRE
- oValid  output  1  instruction valid to decode
- iReady  input  1  decode accepts; transfer = oValid & iReady
- oInstr  output  IW  instruction
- oPC  output  AW  PC of oInstr

Behaviour:
- Reset is asynchronous, active-low on resetN; clock is iClk.
- Reset values: state=IDLE, oValid=0, oRE=0, slot=0, PC=RESET_PC, line register=0.
- Line layout: slot k = iRD[IW*(k+1)-1 : IW*k]. Slot 0 is the lowest address.
- PC arithmetic: PC advances by 4 per transfer, mod 2^AW. slot = PC[3:2]. iRedirectPC[1:0] is ignored and forced to 0.
- oRE is combinational: oRE = (state==IDLE) & ~iEmpty & ~iClear. It is never asserted in WAIT, in HOLD, or in a clear cycle (base build).
- IDLE: if oRE=1, go to WAIT. Otherwise stay.
- WAIT: capture iRD into the line register, then go to HOLD. slot is unchanged; it keeps the value of PC[3:2].
- HOLD:
  - oValid=1, oInstr = line[slot], oPC = PC.
  - oInstr and oPC are stable while oValid & ~iReady.
  - On transfer: PC+=4. If slot==3, go to IDLE; else slot+1 and stay in HOLD.
- First line after redirect: issue starts at slot iRedirectPC[3:2]. Lower slots are skipped and never presented.
- iClear (highest priority, any state):
  - Next state is IDLE, oValid=0 next cycle, PC=iRedirectPC.
  - Any transfer in that cycle is ignored; PC is not incremented.
  - If the clear hits WAIT, the iRD arriving that cycle is discarded.
- Empty boundary: in IDLE with iEmpty=1, oValid=0 and oRE=0. Stays in IDLE indefinitely.
- Full boundary: this block has no full condition. Buffer fullness is the upstream writer's concern.
- Base throughput: 4 instructions per 6 cycles (IDLE + WAIT bubble per line). No instruction is ever duplicated or dropped except by iClear.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, with no special handling.

Optional Feature:
- Macro: IFETCHER_ISPLIT_PREFETCH_EN.
- Defined:
  - Adds a one-line shadow register with a valid bit, plus a read-pending flag.
  - In HOLD, oRE = ~shadowValid & ~pending & ~iEmpty & ~iClear. The cycle after oRE, iRD is written to the shadow register.
  - On a slot-3 transfer with shadowValid=1 (or shadow being filled that same cycle): load shadow into line, slot=0, stay in HOLD. Consecutive lines issue with zero bubbles.
  - iClear invalidates the shadow and drops the pending read.
  - Steady-state throughput with a non-empty buffer and iReady=1: 1 instruction per cycle.
- Undefined: no shadow register; base behaviour exactly as above.

Test Plan:
- Reset, then one line 0x44444444_33333333_22222222_11111111 with iReady=1:
  - Response: oRE pulses for 1 cycle.
  - oValid rises 2 cycles after oRE.
  - oInstr = 11111111, 22222222, 33333333, 44444444 with oPC = 0x0, 0x4, 0x8, 0xC.
  - Returns to IDLE.
- Backpressure: iReady=0 for 3 cycles on slot 1 -> oInstr=22222222 and oPC=0x4 held stable; oRE stays 0; transfer completes when iReady=1.
- Redirect: iClear with iRedirectPC=0x108, then line AAAA..DDDD -> first issue is slot 2 (oPC=0x108), then slot 3 (0x10C); slots 0-1 are never issued.
- Clear in WAIT (cycle after oRE) -> the captured iRD is discarded, oValid stays 0, and the next line issues starting at the redirect PC.
- Empty buffer: iEmpty=1 for 10 cycles -> oRE=0 and oValid=0 throughout. resetN asserted mid-HOLD -> oValid=0 immediately and PC=RESET_PC.
- With IFETCHER_ISPLIT_PREFETCH_EN, 3 lines queued, iReady=1 -> 12 consecutive transfers in 12 cycles after the first oValid; PC runs 0x0 to 0x2C.
